// File: rtl/neuron_hs_pkg.sv
// Shared types and constants for the neuron handshake blocks.
//   tx_state_t      : transmitter FSM states
//   TIMEOUT_CYC_DEF : default handshake-phase timeout in cycles
//   TO_W            : timeout counter width for the default timeout
//   to_cnt_w()      : timeout counter width for an arbitrary timeout
package neuron_hs_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      REQ_HI = 2'd2,
      REQ_LO = 2'd3
   } tx_state_t;

   localparam int unsigned TIMEOUT_CYC_DEF = 1024;
   localparam int unsigned TO_W            = $clog2(TIMEOUT_CYC_DEF + 1);

   function automatic int unsigned to_cnt_w(input int unsigned cyc);
      return $clog2(cyc + 1);
   endfunction

endpackage

// File: rtl/sync_ff.sv
// N-flop synchronizer for a single asynchronous bit.
//   clk, rst_n : clock, asynchronous active-low reset (flops reset to 0)
//   d          : asynchronous input
//   q          : synchronized output, STAGES edges after d
module sync_ff #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sr_q;

   // Shift chain; first flop is the only one that may go metastable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sr_q <= '0;
      else        sr_q <= {sr_q[STAGES-2:0], d};
   end

   assign q = sr_q[STAGES-1];

endmodule

// File: rtl/neuron_spike_tx.sv
// Clocked spike transmitter: buffers spike words from a valid/ready port in a
// small FIFO and sends each one to the asynchronous neuron chain as bundled
// data followed by a 4-phase return-to-zero req/ack handshake.
//   clk, rst_n           : clock, asynchronous active-low reset
//   s_valid/s_ready/s_data : spike word input port (s_ready = !full)
//   req, data            : request and bundled data toward the neuron (flopped)
//   ack                  : asynchronous acknowledge from the neuron
//   busy                 : handshake FSM not idle
//   timeout_err, err_clr : sticky handshake-phase timeout flag and its clear
module neuron_spike_tx
   import neuron_hs_pkg::*;
#(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned SETUP_CYC   = 2,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_data,
   output logic             req,
   input  logic             ack,
   output logic [WIDTH-1:0] data,
   output logic             busy,
   output logic             timeout_err,
   input  logic             err_clr
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
   localparam int unsigned TW = (to_cnt_w(TIMEOUT_CYC) > TO_W) ? to_cnt_w(TIMEOUT_CYC) : TO_W;

   // FIFO storage and wrap-bit pointers
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr_q, rd_ptr_q;
   logic             full, empty, push, pop;

   // FSM and datapath registers
   tx_state_t        state_q, state_d;
   logic             req_q, req_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [TW-1:0]    to_cnt_q, to_cnt_d;
   logic             to_set, stay;
   logic             err_q;
   logic [WIDTH-1:0] data_q;
   logic             ack_s;

   assign full    = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign push    = s_valid && !full;
   assign s_ready = !full;

   // Ack synchronizer; the FSM never looks at the raw ack.
   sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (ack),
      .q     (ack_s)
   );

   // FIFO storage (contents are don't-care while empty, so no reset)
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q[AW-1:0]] <= s_data;
   end

   // FIFO pointers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

   // Handshake FSM next state; launch only when the neuron has returned to zero.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      cnt_d   = cnt_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty && !ack_s) begin
               pop     = 1'b1;
               cnt_d   = CW'(SETUP_CYC - 1);
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (cnt_q == '0) begin
               req_d   = 1'b1;
               state_d = REQ_HI;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         REQ_HI: begin
            if (ack_s) begin
               req_d   = 1'b0;
               state_d = REQ_LO;
            end
         end
         REQ_LO: begin
            if (!ack_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Phase timeout: counts while waiting in one phase, fires once on reaching the limit.
   always_comb begin
      stay     = ((state_q == REQ_HI) || (state_q == REQ_LO)) && (state_d == state_q);
      to_cnt_d = '0;
      to_set   = 1'b0;
      if (stay) begin
         to_set   = (to_cnt_q == TW'(TIMEOUT_CYC - 1));
         to_cnt_d = (to_cnt_q == TW'(TIMEOUT_CYC)) ? to_cnt_q : to_cnt_q + TW'(1);
      end
   end

   // State, request, bundled data and error flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         req_q    <= 1'b0;
         cnt_q    <= '0;
         to_cnt_q <= '0;
         err_q    <= 1'b0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         cnt_q    <= cnt_d;
         to_cnt_q <= to_cnt_d;
         if (to_set)       err_q <= 1'b1;
         else if (err_clr) err_q <= 1'b0;
         if (pop) data_q <= mem[rd_ptr_q[AW-1:0]];
      end
   end

   assign req         = req_q;
   assign data        = data_q;
   assign busy        = (state_q != IDLE);
   assign timeout_err = err_q;

endmodule

// File: tb/tb_neuron_spike_tx.sv
// Directed self-checking bench for neuron_spike_tx with a behavioural neuron
// responder (ack follows req after resp_dly) or a manually driven ack.
module tb_neuron_spike_tx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       s_valid = 1'b0;
   logic       s_ready;
   logic [7:0] s_data = 8'h00;
   logic       req;
   logic       ack;
   logic [7:0] data;
   logic       busy;
   logic       timeout_err;
   logic       err_clr = 1'b0;

   logic       auto_ack = 1'b0;
   logic       man_ack = 1'b0;
   logic       resp_ack = 1'b0;
   int         resp_dly = 3;

   int         checks = 0;
   int         errors = 0;

   // Monitor state
   logic [7:0] data_prev = 8'h00;
   logic       req_prev = 1'b0;
   logic       acks_prev = 1'b0;
   logic       rst_prev = 1'b0;
   int         viol = 0;
   logic [7:0] delivered [$];

   always #5 clk = ~clk;

   neuron_spike_tx dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .req         (req),
      .ack         (ack),
      .data        (data),
      .busy        (busy),
      .timeout_err (timeout_err),
      .err_clr     (err_clr)
   );

   // Behavioural neuron: ack follows req after a delay
   always @(req) resp_ack <= #(resp_dly) req;
   assign ack = auto_ack ? resp_ack : man_ack;

   // Record delivered words and any data change while the handshake is active
   always @(negedge clk) begin
      if (rst_n && rst_prev && (data !== data_prev) && (req_prev || acks_prev)) viol++;
      if (rst_n && req && !req_prev) delivered.push_back(data);
      data_prev = data;
      req_prev  = req;
      acks_prev = dut.ack_s;
      rst_prev  = rst_n;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         0:       return req;
         1:       return busy;
         default: return s_ready;
      endcase
   endfunction

   // Bounded wait on req (0), busy (1) or s_ready (2); expiry is a failed check
   task automatic wait_for(input int sel, input logic val, input int budget, input string tag);
      int k = 0;
      while ((sig(sel) !== val) && (k < budget)) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 32'(sig(sel)), 32'(val));
   endtask

   // Offer a word, wait for acceptance, return at the negedge of the cycle after acceptance
   task automatic push(input logic [7:0] v);
      s_data  = v;
      s_valid = 1'b1;
      wait_for(2, 1'b1, 300, "push_ready");
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   // Single word with ideal responder from idle: exact cycle-by-cycle timing
   task automatic timing_check(input logic [7:0] v, input string t);
      push(v);                                          // cycle 1
      chk({t, "_busy_c1"}, 32'(busy), 32'd0);
      @(negedge clk);                                   // cycle 2
      chk({t, "_data_c2"}, 32'(data), 32'(v));
      chk({t, "_busy_c2"}, 32'(busy), 32'd1);
      chk({t, "_req_c2"}, 32'(req), 32'd0);
      @(negedge clk);                                   // cycle 3
      chk({t, "_req_c3"}, 32'(req), 32'd0);
      @(negedge clk);                                   // cycle 4
      chk({t, "_req_c4"}, 32'(req), 32'd1);
      repeat (2) @(negedge clk);                        // cycle 6
      chk({t, "_req_c6"}, 32'(req), 32'd1);
      @(negedge clk);                                   // cycle 7: 3 edges after ack seen
      chk({t, "_req_c7"}, 32'(req), 32'd0);
      chk({t, "_data_c7"}, 32'(data), 32'(v));
      repeat (2) @(negedge clk);                        // cycle 9
      chk({t, "_busy_c9"}, 32'(busy), 32'd1);
      @(negedge clk);                                   // cycle 10
      chk({t, "_busy_c10"}, 32'(busy), 32'd0);
   endtask

   initial begin
      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_req", 32'(req), 32'd0);
      chk("rst_data", 32'(data), 32'd0);
      chk("rst_s_ready", 32'(s_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(timeout_err), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 1: single word, ideal responder
      auto_ack = 1'b1;
      resp_dly = 3;
      timing_check(8'hA5, "t1");

      // 2: fill FIFO while ack is held high, then drain with a slow responder
      delivered.delete();
      auto_ack = 1'b0;
      man_ack  = 1'b1;
      repeat (3) @(negedge clk);
      for (int i = 1; i <= 4; i++) push(8'(i));
      chk("t2_s_ready_full", 32'(s_ready), 32'd0);
      chk("t2_no_launch", 32'(busy), 32'd0);
      resp_dly = 35;
      auto_ack = 1'b1;
      push(8'h05);
      for (int k = 0; (k < 400) && (delivered.size() < 5); k++) @(negedge clk);
      chk("t2_count", 32'(delivered.size()), 32'd5);
      wait_for(1, 1'b0, 100, "t2_idle");
      for (int i = 0; i < 5; i++)
         chk($sformatf("t2_word%0d", i), 32'(delivered[i]), 32'(i + 1));
      chk("t2_data_stable", 32'(viol), 32'd0);

      // 3: timeout with ack held low
      repeat (5) @(negedge clk);
      auto_ack = 1'b0;
      man_ack  = 1'b0;
      push(8'h77);
      wait_for(0, 1'b1, 10, "t3_req_rise");
      repeat (1023) @(negedge clk);
      chk("t3_err_before", 32'(timeout_err), 32'd0);
      @(negedge clk);
      chk("t3_err_set", 32'(timeout_err), 32'd1);
      chk("t3_req_held", 32'(req), 32'd1);
      man_ack = 1'b1;
      wait_for(0, 1'b0, 10, "t3_req_fall");
      man_ack = 1'b0;
      wait_for(1, 1'b0, 10, "t3_idle");
      chk("t3_err_sticky", 32'(timeout_err), 32'd1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("t3_err_clr", 32'(timeout_err), 32'd0);
      push(8'h78);
      wait_for(0, 1'b1, 10, "t3b_req_rise");
      repeat (1023) @(negedge clk);
      chk("t3b_err_before", 32'(timeout_err), 32'd0);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("t3b_set_wins", 32'(timeout_err), 32'd1);
      man_ack = 1'b1;
      wait_for(0, 1'b0, 10, "t3b_req_fall");
      man_ack = 1'b0;
      wait_for(1, 1'b0, 10, "t3b_idle");

      // 4: ack high across reset release, FIFO loaded
      rst_n   = 1'b0;
      man_ack = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      push(8'h3C);
      repeat (5) @(negedge clk);
      chk("t4_no_launch_busy", 32'(busy), 32'd0);
      chk("t4_no_launch_req", 32'(req), 32'd0);
      chk("t4_s_ready", 32'(s_ready), 32'd1);
      resp_dly = 3;
      auto_ack = 1'b1;
      repeat (2) @(negedge clk);
      chk("t4_wait_sync", 32'(busy), 32'd0);
      @(negedge clk);
      chk("t4_launch", 32'(busy), 32'd1);
      chk("t4_data", 32'(data), 32'h3C);
      wait_for(1, 1'b0, 40, "t4_idle");

      // 5: reset during REQ_HI
      repeat (3) @(negedge clk);
      auto_ack = 1'b0;
      man_ack  = 1'b0;
      push(8'h11);
      push(8'h22);
      wait_for(0, 1'b1, 10, "t5_req_rise");
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_req_async", 32'(req), 32'd0);
      chk("t5_s_ready", 32'(s_ready), 32'd1);
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_data", 32'(data), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("t5_fifo_empty", 32'(busy), 32'd0);
      resp_dly = 3;
      auto_ack = 1'b1;
      timing_check(8'h5A, "t5");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
